// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: load-use and branch-operand stalls,
// MDU busy interlock, IF/ID flush on taken branch/jump, and a saturating stall counter.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 12,
    parameter int CNT_W       = 5,
    parameter int PERF_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        IFID_RegisterRs,
    input  logic [4:0]        IFID_RegisterRt,
    input  logic              IFID_UsesRt,
    input  logic              IFID_Branch,
    input  logic              IFID_ReadsHiLo,
    input  logic              IFID_MduOp,
    input  logic              IDEX_MemRead,
    input  logic              IDEX_RegWrite,
    input  logic [4:0]        IDEX_RegisterRt,
    input  logic [4:0]        IDEX_RegisterRd,
    input  logic              EXMEM_MemRead,
    input  logic [4:0]        EXMEM_RegisterRd,
    input  logic              mdu_start,
    input  logic              mdu_is_div,
    input  logic              BranchTaken,
    input  logic              Jump,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic              IFID_Flush,
    output logic              IDEX_Bubble,
    output logic              mdu_busy,
    output logic              mdu_done,
    output logic [PERF_W-1:0] stall_cycles
);

    // state  | meaning
    // RUN    | normal issue; data hazards evaluated each cycle
    // BR_LD2 | second stall cycle of a branch waiting on a load result
    typedef enum logic {RUN = 1'b0, BR_LD2 = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    mdu_cnt_q, mdu_cnt_d;
    logic [PERF_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic busy_int, mdu_stall, br_ld_ex, load_use, br_alu, br_ld_mem, data_stall, stall;

    // $zero never creates a dependency
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    always_comb begin
        busy_int  = (mdu_cnt_q != '0);
        mdu_stall = busy_int && (IFID_ReadsHiLo || IFID_MduOp);

        br_ld_ex  = IFID_Branch && IDEX_MemRead &&
                    (reg_match(IFID_RegisterRs, IDEX_RegisterRt) ||
                     reg_match(IFID_RegisterRt, IDEX_RegisterRt));
        load_use  = !IFID_Branch && IDEX_MemRead &&
                    (reg_match(IFID_RegisterRs, IDEX_RegisterRt) ||
                     (IFID_UsesRt && reg_match(IFID_RegisterRt, IDEX_RegisterRt)));
        br_alu    = IFID_Branch && IDEX_RegWrite &&
                    (reg_match(IFID_RegisterRs, IDEX_RegisterRd) ||
                     reg_match(IFID_RegisterRt, IDEX_RegisterRd));
        br_ld_mem = IFID_Branch && EXMEM_MemRead &&
                    (reg_match(IFID_RegisterRs, EXMEM_RegisterRd) ||
                     reg_match(IFID_RegisterRt, EXMEM_RegisterRd));

        data_stall = (state_q == RUN) && (br_ld_ex || load_use || br_alu || br_ld_mem);
        stall      = mdu_stall || (state_q == BR_LD2) || data_stall;

        // an MDU interlock freezes the hazard FSM so a pending BR_LD2 is not lost
        if (mdu_stall)
            state_d = state_q;
        else if (state_q == BR_LD2)
            state_d = RUN;
        else if (br_ld_ex)
            state_d = BR_LD2;
        else
            state_d = RUN;

        if (mdu_start)
            mdu_cnt_d = mdu_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
        else if (busy_int)
            mdu_cnt_d = mdu_cnt_q - CNT_W'(1);
        else
            mdu_cnt_d = mdu_cnt_q;

        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        else
            stall_cnt_d = stall_cnt_q;
    end

    always_comb begin
        if (reset) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
            IFID_Flush  = 1'b1;
            mdu_busy    = 1'b0;
            mdu_done    = 1'b0;
        end else begin
            PCWrite     = !stall;
            IFIDWrite   = !stall;
            IDEX_Bubble = stall;
            IFID_Flush  = (BranchTaken || Jump) && !stall;
            mdu_busy    = busy_int;
            mdu_done    = (mdu_cnt_q == CNT_W'(1)) && !mdu_start;
        end
    end

    assign stall_cycles = stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            mdu_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mdu_cnt_q   <= mdu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
